// File: rtl/ddr_lane_tx.sv
// ---------------------------------------------------------------------------
// ddr_lane_tx
// Byte-stream to DDR-lane transmitter. Each clk cycle carries one dibit:
// out_d0 feeds the rising-edge half and out_d180 the falling-edge half of an
// output DDR IO pair. A frame is preamble (0x55 bytes) + SFD + payload, every
// byte sent LSB first, followed by an idle inter-frame gap.
//
// Ports
//   clk       in   PLL global clock
//   rst_n     in   synchronous, active-low reset
//   s_data    in   payload byte, taken only on handshake (s_valid & s_ready)
//   s_valid   in   payload byte available
//   s_last    in   marks s_data as the final byte of the frame
//   s_ready   out  one-cycle pulse: the presented byte is taken this cycle
//   out_d0    out  first bit of the current dibit
//   out_d180  out  second bit of the current dibit
//   busy      out  high whenever the transmitter is not idle
//   underrun  out  one-cycle pulse: frame aborted, no byte at handshake
// ---------------------------------------------------------------------------
module ddr_lane_tx #(
   parameter int unsigned PREAMBLE_BYTES = 7,
   parameter logic [7:0]  SFD            = 8'hD5,
   parameter int unsigned IFG_CYCLES     = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   input  logic       s_last,
   output logic       s_ready,
   output logic       out_d0,
   output logic       out_d180,
   output logic       busy,
   output logic       underrun
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_PRE  = 3'd1;
   localparam logic [2:0] ST_SFD  = 3'd2;
   localparam logic [2:0] ST_DATA = 3'd3;
   localparam logic [2:0] ST_GAP  = 3'd4;

   localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_BYTES - 1);
   localparam logic [7:0] GAP_LAST = 8'(IFG_CYCLES - 1);

   // state_q and the counters describe the dibit currently on the outputs
   logic [2:0] state_q, state_d;
   logic [1:0] dib_q, dib_d;
   logic [3:0] pre_cnt_q, pre_cnt_d;
   logic [7:0] gap_cnt_q, gap_cnt_d;
   logic [7:0] byte_q, byte_d;
   logic       last_q, last_d;
   logic       out_d0_q, out_d0_d;
   logic       out_d180_q, out_d180_d;
   logic       s_ready_q, s_ready_d;
   logic       busy_q, busy_d;
   logic       underrun_q, underrun_d;

   // Next-state, counter and byte-load logic
   always_comb begin
      state_d    = state_q;
      dib_d      = dib_q;
      pre_cnt_d  = pre_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      byte_d     = byte_q;
      last_d     = last_q;
      underrun_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (s_valid) begin
               state_d   = ST_PRE;
               dib_d     = 2'd0;
               pre_cnt_d = 4'd0;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_PRE: begin
            dib_d = dib_q + 2'd1;
            if (dib_q == 2'd3) begin
               if (pre_cnt_q == PRE_LAST) begin
                  // The SFD is serialised through the same byte path as payload
                  state_d = ST_SFD;
                  byte_d  = SFD;
                  last_d  = 1'b0;
               end else begin
                  pre_cnt_d = pre_cnt_q + 4'd1;
               end
            end else begin
               state_d = ST_PRE;
            end
         end
         ST_SFD, ST_DATA: begin
            dib_d = dib_q + 2'd1;
            if (dib_q == 2'd3) begin
               if (last_q) begin
                  state_d   = ST_GAP;
                  gap_cnt_d = 8'd0;
               end else if (s_valid) begin
                  state_d = ST_DATA;
                  byte_d  = s_data;
                  last_d  = s_last;
               end else begin
                  // Handshake with nothing offered: abandon the frame
                  state_d    = ST_GAP;
                  gap_cnt_d  = 8'd0;
                  underrun_d = 1'b1;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output values for the dibit that will be shown next cycle
   always_comb begin
      out_d0_d   = 1'b0;
      out_d180_d = 1'b0;
      case (state_d)
         ST_PRE: begin
            out_d0_d   = 1'b1;
            out_d180_d = 1'b0;
         end
         ST_SFD, ST_DATA: begin
            out_d0_d   = byte_d[{dib_d, 1'b0}];
            out_d180_d = byte_d[{dib_d, 1'b1}];
         end
         default: begin
            out_d0_d   = 1'b0;
            out_d180_d = 1'b0;
         end
      endcase
      // Ready coincides with the last dibit of the SFD or of a non-last byte
      s_ready_d = ((state_d == ST_SFD) || (state_d == ST_DATA)) &&
                  (dib_d == 2'd3) && !last_d;
      busy_d    = (state_d != ST_IDLE);
   end

   // State and registered-output update with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         dib_q      <= 2'd0;
         pre_cnt_q  <= 4'd0;
         gap_cnt_q  <= 8'd0;
         byte_q     <= 8'd0;
         last_q     <= 1'b0;
         out_d0_q   <= 1'b0;
         out_d180_q <= 1'b0;
         s_ready_q  <= 1'b0;
         busy_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         dib_q      <= dib_d;
         pre_cnt_q  <= pre_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         byte_q     <= byte_d;
         last_q     <= last_d;
         out_d0_q   <= out_d0_d;
         out_d180_q <= out_d180_d;
         s_ready_q  <= s_ready_d;
         busy_q     <= busy_d;
         underrun_q <= underrun_d;
      end
   end

   assign out_d0   = out_d0_q;
   assign out_d180 = out_d180_q;
   assign s_ready  = s_ready_q;
   assign busy     = busy_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_ddr_lane_tx.sv
// ---------------------------------------------------------------------------
// tb_ddr_lane_tx
// Self-checking bench for ddr_lane_tx. For each frame the expected per-cycle
// lane trace {out_d0, out_d180, s_ready, busy, underrun} is built from the
// frame format (preamble, SFD, payload dibits, gap) and compared cycle by
// cycle. Directed frames cover reset, single/multi-byte frames, underrun,
// mid-frame reset and early s_valid in the gap; random frames follow.
// ---------------------------------------------------------------------------
module tb_ddr_lane_tx;

   localparam int PRE = 7;
   localparam int IFG = 12;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_last;
   logic       s_ready;
   logic       out_d0;
   logic       out_d180;
   logic       busy;
   logic       underrun;

   int         n_chk  = 0;
   int         n_fail = 0;
   int         frame_no = 0;
   logic [7:0] fb [0:7];
   logic [7:0] nxt_b0;
   logic       nxt_last;
   logic [7:0] sfd_v = 8'hD5;

   ddr_lane_tx #(
      .PREAMBLE_BYTES (PRE),
      .SFD            (8'hD5),
      .IFG_CYCLES     (IFG)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_last   (s_last),
      .s_ready  (s_ready),
      .out_d0   (out_d0),
      .out_d180 (out_d180),
      .busy     (busy),
      .underrun (underrun)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] obs();
      return {out_d0, out_d180, s_ready, busy, underrun};
   endfunction

   task automatic chk_eq(input string tag, input logic [4:0] act, input logic [4:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got {d0,d180,rdy,busy,udr}=%b expected %b", tag, act, exp);
      end
   endtask

   task automatic idle_cycles(input int n);
      s_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk_eq($sformatf("idle%0d", i), obs(), 5'b00000);
      end
   endtask

   // Called at a negedge of an idle cycle; that cycle becomes T.
   // udr_k >= 1: only udr_k bytes are offered, next handshake fails.
   // gap_raise >= 0: s_valid (next frame byte) raised in that gap cycle.
   // abort_at >= 0: rst_n pulled low for one cycle at that trace entry.
   task automatic run_frame(input int n, input int udr_k, input int gap_raise, input int abort_at);
      logic [4:0] exp_q[$];
      int         m, avail, hs_done, gap_base;
      bit         udr;
      udr      = (udr_k >= 1);
      m        = udr ? udr_k : n;
      avail    = m;
      gap_base = 4 * PRE + 4 + 4 * m;
      frame_no++;
      for (int i = 0; i < 4 * PRE; i++) exp_q.push_back(5'b10010);
      for (int j = 0; j < 4; j++)
         exp_q.push_back({sfd_v[2*j], sfd_v[2*j+1], (j == 3), 1'b1, 1'b0});
      for (int b = 0; b < m; b++)
         for (int j = 0; j < 4; j++)
            exp_q.push_back({fb[b][2*j], fb[b][2*j+1],
                             (j == 3) && !(!udr && b == n - 1), 1'b1, 1'b0});
      for (int g = 0; g < IFG; g++) exp_q.push_back({4'b0001, udr && (g == 0)});
      exp_q.push_back(5'b00000);

      hs_done = 0;
      s_valid = 1'b1;
      s_data  = fb[0];
      s_last  = (n == 1);
      for (int e = 0; e < exp_q.size(); e++) begin
         @(negedge clk);
         chk_eq($sformatf("frm%0d T+%0d", frame_no, e + 1), obs(), exp_q[e]);
         if (e == abort_at) begin
            rst_n = 1'b0;
            @(negedge clk);
            chk_eq($sformatf("frm%0d rst", frame_no), obs(), 5'b00000);
            rst_n   = 1'b1;
            s_valid = 1'b0;
            return;
         end
         if (hs_done < avail) begin
            s_valid = 1'b1;
            s_data  = fb[hs_done];
            s_last  = (hs_done == n - 1);
         end else if (gap_raise >= 0 && e >= gap_base + gap_raise) begin
            s_valid = 1'b1;
            s_data  = nxt_b0;
            s_last  = nxt_last;
         end else begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            s_last  = 1'($urandom);
         end
         if (exp_q[e][2]) hs_done++;
      end
   endtask

   initial begin
      int n, k;
      // Reset held with s_valid high
      rst_n   = 1'b0;
      s_valid = 1'b1;
      s_data  = 8'hFF;
      s_last  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk_eq("reset", obs(), 5'b00000);
      end
      s_valid = 1'b0;
      rst_n   = 1'b1;
      idle_cycles(2);

      // One-byte frame 0xA5
      fb[0] = 8'hA5;
      run_frame(1, -1, -1, -1);

      // Three-byte frame, back-to-back handshakes
      fb[0] = 8'h01; fb[1] = 8'h80; fb[2] = 8'hFF;
      run_frame(3, -1, -1, -1);

      // Underrun after two accepted bytes
      fb[0] = 8'h3A; fb[1] = 8'hC6; fb[2] = 8'h99;
      run_frame(3, 2, -1, -1);

      // Reset mid-DATA, then a clean frame
      fb[0] = 8'h5E; fb[1] = 8'h21;
      run_frame(2, -1, -1, 4 * PRE + 4 + 2);
      idle_cycles(1);
      fb[0] = 8'hA5;
      run_frame(1, -1, -1, -1);

      // s_valid raised in gap cycle 5 must wait for IDLE
      fb[0]    = 8'h77;
      nxt_b0   = 8'h3C;
      nxt_last = 1'b1;
      run_frame(1, -1, 4, -1);
      fb[0] = 8'h3C;
      run_frame(1, -1, -1, -1);

      // Random frames
      for (int f = 0; f < 20; f++) begin
         idle_cycles($urandom_range(0, 3));
         n = $urandom_range(1, 5);
         for (int b = 0; b < n; b++) fb[b] = 8'($urandom);
         k = -1;
         if (n >= 2 && $urandom_range(0, 3) == 0) k = $urandom_range(1, n - 1);
         run_frame(n, k, -1, -1);
      end
      idle_cycles(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
